// File: rtl/alu_arbiter.sv
// alu_arbiter: two-requester round-robin front end for a shared
// combinational ALU, with one registered response channel.
module alu_arbiter #(
    parameter int WIDTH = 4,
    parameter int OPW   = 4,
    parameter int CONDW = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic [OPW-1:0]   req0_op,
    output logic             req0_ready,
    input  logic             req1_valid,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic [OPW-1:0]   req1_op,
    output logic             req1_ready,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [OPW-1:0]   alu_op,
    input  logic [WIDTH-1:0] alu_c,
    input  logic [CONDW-1:0] alu_cond,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [WIDTH-1:0] rsp_c,
    output logic [CONDW-1:0] rsp_cond,
    output logic             busy,
    output logic [7:0]       op_count
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t state;
    state_t state_nx;

    logic gnt_vld;
    logic gnt_id;
    logic last_grant;
    logic id_reg;
    logic accept;
    logic rsp_done;

    // Round-robin pick: on a tie the requester not granted last time wins
    always_comb begin
        gnt_vld = 1'b0;
        gnt_id  = 1'b0;
        case ({req1_valid, req0_valid})
            2'b01: begin
                gnt_vld = 1'b1;
                gnt_id  = 1'b0;
            end
            2'b10: begin
                gnt_vld = 1'b1;
                gnt_id  = 1'b1;
            end
            2'b11: begin
                gnt_vld = 1'b1;
                gnt_id  = ~last_grant;
            end
            default: begin
                gnt_vld = 1'b0;
                gnt_id  = 1'b0;
            end
        endcase
    end

    // Next-state and handshake outputs; ready is held low while in reset
    always_comb begin
        state_nx   = state;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        rsp_valid  = 1'b0;
        busy       = 1'b0;
        accept     = 1'b0;
        rsp_done   = 1'b0;
        unique case (state)
            IDLE: begin
                req0_ready = rst_n && gnt_vld && !gnt_id;
                req1_ready = rst_n && gnt_vld && gnt_id;
                accept     = rst_n && gnt_vld;
                if (accept) state_nx = EXEC;
            end
            EXEC: begin
                busy     = 1'b1;
                state_nx = RESP;
            end
            RESP: begin
                busy      = 1'b1;
                rsp_valid = 1'b1;
                rsp_done  = rsp_ready;
                if (rsp_ready) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    // Issue the granted command onto the ALU and remember who got it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_a      <= '0;
            alu_b      <= '0;
            alu_op     <= '0;
            id_reg     <= 1'b0;
            last_grant <= 1'b1;
        end else if (accept) begin
            alu_a      <= gnt_id ? req1_a  : req0_a;
            alu_b      <= gnt_id ? req1_b  : req0_b;
            alu_op     <= gnt_id ? req1_op : req0_op;
            id_reg     <= gnt_id;
            last_grant <= gnt_id;
        end
    end

    // Capture the ALU result one cycle after issue
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_c    <= '0;
            rsp_cond <= '0;
            rsp_id   <= 1'b0;
        end else if (state == EXEC) begin
            rsp_c    <= alu_c;
            rsp_cond <= alu_cond;
            rsp_id   <= id_reg;
        end
    end

    // Count completed responses, wrapping at 256
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)        op_count <= '0;
        else if (rsp_done) op_count <= op_count + 8'd1;
    end

endmodule
